// File: rtl/exe_stage_pipe_if.sv
// exe_stage_pipe_if: upstream command channel, forwarding sources and the
// result channel of the execute stage, bundled together.
// The master side is the pipeline around the stage (ID/EXE register, MEM
// stage, hazard control). The slave side is the execute stage itself.
interface exe_stage_pipe_if #(
  parameter int WIDTH = 32
);
  // Upstream command handshake
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       exe_cmd;

  // Forwarding selects and operands
  logic [1:0]       val1_sel;
  logic [1:0]       val2_sel;
  logic [1:0]       st_val_sel;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] st_value_in;
  logic [WIDTH-1:0] alu_res_mem;
  logic [WIDTH-1:0] result_wb;

  // Downstream result handshake
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] st_value_out;

  // Stall indication to hazard control
  logic             busy;

  modport master (
    output in_valid, exe_cmd,
    output val1_sel, val2_sel, st_val_sel,
    output val1, val2, st_value_in, alu_res_mem, result_wb,
    output out_ready,
    input  in_ready, out_valid, alu_result, st_value_out, busy
  );

  modport slave (
    input  in_valid, exe_cmd,
    input  val1_sel, val2_sel, st_val_sel,
    input  val1, val2, st_value_in, alu_res_mem, result_wb,
    input  out_ready,
    output in_ready, out_valid, alu_result, st_value_out, busy
  );
endinterface

// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: registered execute stage.
// - Forwards both ALU operands and the store value (register / MEM / WB).
// - Runs single-cycle ALU commands.
// - Presents results in a valid/ready output register.
// Optional feature macro: EXE_MUL_EN.
//   When defined, command 11 runs an iterative shift-add multiply with a
//   latency of WIDTH cycles. Only the low WIDTH bits of the product are kept.
//   When undefined, command 11 is treated as a reserved code.
module exe_stage_pipe #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  exe_stage_pipe_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd1;
  localparam logic [3:0] CMD_AND = 4'd2;
  localparam logic [3:0] CMD_OR  = 4'd3;
  localparam logic [3:0] CMD_NOR = 4'd4;
  localparam logic [3:0] CMD_XOR = 4'd5;
  localparam logic [3:0] CMD_SLA = 4'd6;
  localparam logic [3:0] CMD_SLL = 4'd7;
  localparam logic [3:0] CMD_SRA = 4'd8;
  localparam logic [3:0] CMD_SRL = 4'd9;
  localparam logic [3:0] CMD_NOP = 4'd10;

  // --------------------------------------------------------------------------
  // Operand forwarding.
  // Index 0 = val1, index 1 = val2, index 2 = store value.
  // Select codes 0 and 3 both pick the register-file value.
  // --------------------------------------------------------------------------
  logic [1:0]       sel_arr [3];
  logic [WIDTH-1:0] reg_arr [3];
  logic [WIDTH-1:0] fwd_arr [3];

  assign sel_arr[0] = bus.val1_sel;
  assign sel_arr[1] = bus.val2_sel;
  assign sel_arr[2] = bus.st_val_sel;
  assign reg_arr[0] = bus.val1;
  assign reg_arr[1] = bus.val2;
  assign reg_arr[2] = bus.st_value_in;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_fwd
      assign fwd_arr[gi] = (sel_arr[gi] == 2'd1) ? bus.alu_res_mem :
                           (sel_arr[gi] == 2'd2) ? bus.result_wb   :
                                                   reg_arr[gi];
    end
  endgenerate

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] st_fwd;
  logic [SHW-1:0]   shamt;

  assign op_a   = fwd_arr[0];
  assign op_b   = fwd_arr[1];
  assign st_fwd = fwd_arr[2];
  // Only the low SHW bits of operand b form the shift amount.
  assign shamt  = op_b[SHW-1:0];

  // --------------------------------------------------------------------------
  // Single-cycle ALU.
  // Reserved codes (and MUL when it is not built) produce zero.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_out;

  // Combinational ALU result for the command being offered
  always_comb begin
    alu_out = '0;
    case (bus.exe_cmd)
      CMD_ADD: alu_out = op_a + op_b;
      CMD_SUB: alu_out = op_a - op_b;
      CMD_AND: alu_out = op_a & op_b;
      CMD_OR:  alu_out = op_a | op_b;
      CMD_NOR: alu_out = ~(op_a | op_b);
      CMD_XOR: alu_out = op_a ^ op_b;
      CMD_SLA: alu_out = op_a << shamt;
      CMD_SLL: alu_out = op_a << shamt;
      CMD_SRA: alu_out = $unsigned($signed(op_a) >>> shamt);
      CMD_SRL: alu_out = op_a >> shamt;
      CMD_NOP: alu_out = '0;
      default: alu_out = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic             out_valid_reg;
  logic [WIDTH-1:0] alu_result_reg;
  logic [WIDTH-1:0] st_value_reg;

  logic             is_idle;
  logic             in_ready_int;
  logic             accept;
  logic             load_now;
  logic [WIDTH-1:0] load_res;
  logic [WIDTH-1:0] load_st;

  // The output register must be free, or be emptied on this same edge,
  // before a new command is taken.
  assign in_ready_int = is_idle && (!out_valid_reg || bus.out_ready);
  assign accept       = bus.in_valid && in_ready_int;

`ifdef EXE_MUL_EN
  // --------------------------------------------------------------------------
  // Iterative multiplier.
  // The multiplicand shifts left and the multiplier shifts right, so each
  // iteration only needs to look at bit 0 of the multiplier.
  // --------------------------------------------------------------------------
  localparam logic [3:0] CMD_MUL = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [SHW-1:0]   cnt_reg;
  logic [SHW-1:0]   cnt_next;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mcand_next;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] mplier_next;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] st_hold_reg;
  logic [WIDTH-1:0] st_hold_next;
  logic [WIDTH-1:0] acc_sum;
  logic             mul_done;

  // Partial sum of the current iteration; on the last iteration it is the
  // final (truncated) product.
  assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // Next-state and datapath updates of the multiply FSM
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    acc_next     = acc_reg;
    st_hold_next = st_hold_reg;
    mul_done     = 1'b0;
    if (state_reg == ST_IDLE) begin
      if (accept && (bus.exe_cmd == CMD_MUL)) begin
        state_next   = ST_MUL;
        cnt_next     = '0;
        mcand_next   = op_a;
        mplier_next  = op_b;
        acc_next     = '0;
        st_hold_next = st_fwd;
      end
    end else begin
      acc_next    = acc_sum;
      mcand_next  = mcand_reg << 1;
      mplier_next = mplier_reg >> 1;
      cnt_next    = cnt_reg + SHW'(1);
      if (cnt_reg == SHW'(WIDTH - 1)) begin
        mul_done   = 1'b1;
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    end
  end

  // Multiply FSM registers.
  // Reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      st_hold_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      acc_reg     <= acc_next;
      st_hold_reg <= st_hold_next;
    end
  end

  assign is_idle  = (state_reg == ST_IDLE);
  assign load_now = (accept && (bus.exe_cmd != CMD_MUL)) || mul_done;
  assign load_res = mul_done ? acc_sum : alu_out;
  assign load_st  = mul_done ? st_hold_reg : st_fwd;
  assign bus.busy = (state_reg == ST_MUL);
`else
  // Without the multiplier the stage is always idle and every accepted
  // command completes in one cycle.
  assign is_idle  = 1'b1;
  assign load_now = accept;
  assign load_res = alu_out;
  assign load_st  = st_fwd;
  assign bus.busy = 1'b0;
`endif

  // Output register: a new result may load on the same edge that the old
  // one is consumed. A result that is held is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      alu_result_reg <= '0;
      st_value_reg   <= '0;
    end else if (load_now) begin
      out_valid_reg  <= 1'b1;
      alu_result_reg <= load_res;
      st_value_reg   <= load_st;
    end else if (out_valid_reg && bus.out_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  assign bus.in_ready     = in_ready_int;
  assign bus.out_valid    = out_valid_reg;
  assign bus.alu_result   = alu_result_reg;
  assign bus.st_value_out = st_value_reg;

endmodule

// File: tb/tb_exe_stage_pipe.sv
// tb_exe_stage_pipe: directed and random stimulus for exe_stage_pipe.
// Each cycle is checked against a transaction-level reference model.
// The model keeps the output slot and a countdown for a multiply in flight.
// Define EXE_MUL_EN for both the bench and the RTL to cover the multiplier.
module tb_exe_stage_pipe;

  localparam int W = 32;
`ifdef EXE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_stage_pipe_if #(.WIDTH(W)) bus ();

  exe_stage_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_ov       = 1'b0;
  logic [31:0] m_res      = '0;
  logic [31:0] m_st       = '0;
  int          m_mul_left = 0;
  logic [31:0] m_mul_val  = '0;
  logic [31:0] m_mul_st   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rv,
                                      input logic [31:0] mem, input logic [31:0] wb);
    if (sel == 2'd1) return mem;
    if (sel == 2'd2) return wb;
    return rv;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] ones;
    sh   = b % 32;
    ones = 32'hFFFF_FFFF;
    case (cmd)
      4'd0:       return a + b;
      4'd1:       return a - b;
      4'd2:       return a & b;
      4'd3:       return a | b;
      4'd4:       return ~(a | b);
      4'd5:       return a ^ b;
      4'd6, 4'd7: return a << sh;
      4'd8:       return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
      4'd9:       return a >> sh;
      default:    return 32'h0;
    endcase
  endfunction

  // One clock cycle: check in_ready, advance the model over the edge, then
  // check the registered outputs.
  task automatic tick(input string tag);
    bit          rdy, acc;
    logic [3:0]  c;
    logic [31:0] a, b, s;
    #1;
    rdy = (m_mul_left == 0) && (!m_ov || bus.out_ready);
    if (!rst) check({tag, "/in_ready"}, bus.in_ready, rdy);
    acc = bus.in_valid && rdy;
    c   = bus.exe_cmd;
    a   = fwd(bus.val1_sel,   bus.val1,        bus.alu_res_mem, bus.result_wb);
    b   = fwd(bus.val2_sel,   bus.val2,        bus.alu_res_mem, bus.result_wb);
    s   = fwd(bus.st_val_sel, bus.st_value_in, bus.alu_res_mem, bus.result_wb);
    @(posedge clk);
    #1;
    if (rst) begin
      m_ov = 0; m_res = '0; m_st = '0; m_mul_left = 0;
    end else begin
      if (m_ov && bus.out_ready) m_ov = 0;
      if (m_mul_left > 0) begin
        m_mul_left--;
        if (m_mul_left == 0) begin
          m_ov = 1; m_res = m_mul_val; m_st = m_mul_st;
        end
      end
      if (acc) begin
        if (MUL_EN && c == 4'd11) begin
          m_mul_left = W; m_mul_val = a * b; m_mul_st = s;
        end else begin
          m_ov = 1; m_res = ref_alu(c, a, b); m_st = s;
        end
      end
    end
    check({tag, "/out_valid"}, bus.out_valid, m_ov);
    check({tag, "/busy"}, bus.busy, (m_mul_left > 0));
    if (m_ov) begin
      check({tag, "/alu_result"}, bus.alu_result, m_res);
      check({tag, "/st_value"}, bus.st_value_out, m_st);
    end
    $display("[TB] %s acc=%0d cmd=%0d ov=%0d res=%h st=%h busy=%0d",
             tag, acc, c, bus.out_valid, bus.alu_result, bus.st_value_out, bus.busy);
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [1:0] s1, input logic [31:0] v1,
                       input logic [1:0] s2, input logic [31:0] v2,
                       input logic [1:0] ss, input logic [31:0] sv);
    bus.in_valid    = 1'b1;
    bus.exe_cmd     = cmd;
    bus.val1_sel    = s1;
    bus.val1        = v1;
    bus.val2_sel    = s2;
    bus.val2        = v2;
    bus.st_val_sel  = ss;
    bus.st_value_in = sv;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Runs a multiply to completion and checks its latency and busy length
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int cyc;
    int busy_cnt;
    drive(4'd11, 2'd0, a, 2'd0, b, 2'd0, 32'h5A5A_0000);
    tick({tag, "_acc"});
    idle();
    busy_cnt = bus.busy ? 1 : 0;
    cyc = 0;
    while (!bus.out_valid && cyc < 64) begin
      tick(tag);
      cyc++;
      if (bus.busy) busy_cnt++;
    end
    check({tag, "/latency"}, cyc, W);
    check({tag, "/busy_len"}, busy_cnt, W);
    check({tag, "/product"}, bus.alu_result, exp);
  endtask

  // Watchdog: every loop is bounded, so this is only a last resort
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.exe_cmd = '0;
    bus.val1_sel = '0; bus.val2_sel = '0; bus.st_val_sel = '0;
    bus.val1 = '0; bus.val2 = '0; bus.st_value_in = '0;
    bus.alu_res_mem = '0; bus.result_wb = '0;
    bus.out_ready = 1'b1;
    tick("reset");
    tick("reset");
    rst = 1'b0;
    check("reset/alu_result", bus.alu_result, 32'h0);
    check("reset/st_value", bus.st_value_out, 32'h0);

    // ADD with val1 forwarded from MEM
    bus.alu_res_mem = 32'h10;
    drive(4'd0, 2'd1, 32'hDEAD_BEEF, 2'd0, 32'h5, 2'd0, 32'h77);
    tick("add_fwd");
    check("add_fwd/value", bus.alu_result, 32'h15);
    check("add_fwd/latency", bus.out_valid, 1'b1);

    // Shifts, back to back
    drive(4'd8, 2'd0, 32'h8000_0000, 2'd0, 32'h24, 2'd0, 32'h0);
    tick("sra");
    check("sra/value", bus.alu_result, 32'hF800_0000);
    drive(4'd9, 2'd0, 32'h8000_0000, 2'd0, 32'h24, 2'd0, 32'h0);
    tick("srl");
    check("srl/value", bus.alu_result, 32'h0800_0000);
    drive(4'd7, 2'd0, 32'h1, 2'd0, 32'd31, 2'd0, 32'h0);
    tick("sll");
    check("sll/value", bus.alu_result, 32'h8000_0000);

    // Store value forwarded from WB
    bus.result_wb = 32'hCAFE_0001;
    drive(4'd10, 2'd0, 32'h1, 2'd0, 32'h2, 2'd2, 32'h1234);
    tick("st_wb");
    check("st_wb/st_value", bus.st_value_out, 32'hCAFE_0001);
    check("st_wb/nop_result", bus.alu_result, 32'h0);
    idle();
    tick("drain");

    // Backpressure: the first result is held while the second command waits
    bus.out_ready = 1'b0;
    drive(4'd0, 2'd0, 32'd1, 2'd0, 32'd2, 2'd0, 32'hA);
    tick("hold_a");
    drive(4'd0, 2'd0, 32'd10, 2'd0, 32'd20, 2'd0, 32'hB);
    for (int i = 0; i < 3; i++) begin
      tick("hold");
      check("hold/stable", bus.alu_result, 32'd3);
    end
    bus.out_ready = 1'b1;
    tick("hold_release");
    check("hold_release/second", bus.alu_result, 32'd30);
    idle();
    tick("drain");

`ifdef EXE_MUL_EN
    run_mul("mul_7x6", 32'd7, 32'd6, 32'd42);
    run_mul("mul_ffx2", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    tick("drain");

    // Reset during a multiply aborts it
    drive(4'd11, 2'd0, 32'd9, 2'd0, 32'd9, 2'd0, 32'h0);
    tick("abort_acc");
    idle();
    for (int i = 0; i < 9; i++) tick("abort_run");
    rst = 1'b1;
    tick("abort_rst");
    rst = 1'b0;
    check("abort/busy", bus.busy, 1'b0);
    check("abort/out_valid", bus.out_valid, 1'b0);
    for (int i = 0; i < W + 2; i++) tick("abort_quiet");
    drive(4'd0, 2'd0, 32'd1, 2'd0, 32'd1, 2'd0, 32'h0);
    tick("abort_add");
    check("abort_add/value", bus.alu_result, 32'd2);
    check("abort_add/latency", bus.out_valid, 1'b1);
`else
    drive(4'd11, 2'd0, 32'd7, 2'd0, 32'd6, 2'd0, 32'h0);
    tick("mul_off");
    check("mul_off/value", bus.alu_result, 32'h0);
    check("mul_off/latency", bus.out_valid, 1'b1);
    check("mul_off/busy", bus.busy, 1'b0);
`endif
    idle();
    tick("drain");

    // Random traffic with random backpressure and forwarding
    for (int i = 0; i < 400; i++) begin
      logic [3:0] c;
      c = 4'($urandom_range(0, 15));
      if (c == 4'd11 && $urandom_range(0, 3) != 0) c = 4'd0;
      bus.alu_res_mem = $urandom;
      bus.result_wb   = $urandom;
      drive(c, 2'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
            2'($urandom_range(0, 3)), $urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick("rand");
    end
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < W + 4; i++) tick("final_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
